// File: rtl/pdm_stim_gen.sv
// pdm_stim_gen: multi-channel PDM microphone emulator.
// A prescaled mclk/ce_pdm generator drives a first-order sigma-delta modulator.
// The modulator turns a PCM sample stream into PDM bits. A shared tap line
// gives each channel its own tick delay, which models array arrival skew.
// Optional feature: define PDM_STIM_DITHER_EN to add a 16-bit Galois LFSR.
// The LFSR adds 0/+1 to the modulator comparison so that idle tones break up.
`timescale 1ns/1ps
module pdm_stim_gen #(
  parameter int CH    = 4,
  parameter int W     = 12,
  parameter int PRE_W = 8,
  parameter int OSR   = 64,
  parameter int DLY_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_i,
  input  logic [PRE_W-1:0]  prescaler,
  input  logic [W-1:0]      sample_i,
  input  logic              sample_valid_i,
  output logic              sample_ready_o,
  input  logic [CH*DLY_W-1:0] delay_i,
  output logic              mclk_o,
  output logic              ce_pdm_o,
  output logic [CH-1:0]     pdm_o,
  output logic              underflow_o
);

  localparam int DL_N  = 1 << DLY_W;
  localparam int OSR_W = $clog2(OSR);
  localparam int AW    = W + 2;
  localparam logic signed [AW-1:0] FS_P = AW'(2 ** (W - 1));

  // Clock generator state
  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic             mclk_q, mclk_d;
  logic             ce_q, ce_d;

  // Datapath state
  logic [W-1:0]           hold_q, hold_d;
  logic                   full_q, full_d;
  logic [W-1:0]           cur_q, cur_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [OSR_W-1:0]       osr_q, osr_d;
  logic [DL_N-1:0]        dl_q, dl_d;
  logic [CH-1:0]          pdm_q, pdm_d;
  logic                   primed_q, primed_d;
  logic                   uf_q, uf_d;

  // Modulator scratch
  logic [W-1:0]           x_sel;
  logic signed [AW-1:0]   e;
  logic                   bit_v;

`ifdef PDM_STIM_DITHER_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic signed [AW-1:0] e_cmp;
`endif

  // Outputs come straight from flops. sample_ready_o is the registered
  // inverse of full, so it has no combinational path from sample_valid_i.
  assign sample_ready_o = ~full_q;
  assign mclk_o         = mclk_q;
  assign ce_pdm_o       = ce_q;
  assign pdm_o          = pdm_q;
  assign underflow_o    = uf_q;

  // Prescaler: toggle mclk when cnt reaches prescaler; tick on the rising toggle.
  always_comb begin
    cnt_d  = '0;
    mclk_d = 1'b0;
    ce_d   = 1'b0;
    if (en) begin
      if (cnt_q >= prescaler) begin
        cnt_d  = '0;
        mclk_d = ~mclk_q;
        ce_d   = ~mclk_q;
      end else begin
        cnt_d  = cnt_q + PRE_W'(1);
        mclk_d = mclk_q;
      end
    end
  end

  // Handshake: a transfer happens on a clock edge where sample_valid_i and
  // sample_ready_o are both high. The value is then held in hold_q until the
  // next OSR boundary tick pops it. While full, ready stays low, so a load and
  // a pop never fall in the same cycle. clr_i drops any sample offered with it.
  // Datapath: load, tick-driven modulation, delay line, then the clear override.
  always_comb begin
    hold_d   = hold_q;
    full_d   = full_q;
    cur_d    = cur_q;
    acc_d    = acc_q;
    osr_d    = osr_q;
    dl_d     = dl_q;
    pdm_d    = pdm_q;
    primed_d = primed_q;
    uf_d     = uf_q;
    x_sel    = cur_q;
    e        = '0;
    bit_v    = 1'b0;
`ifdef PDM_STIM_DITHER_EN
    lfsr_d   = lfsr_q;
    e_cmp    = '0;
`endif

    if (sample_valid_i && !full_q) begin
      hold_d = sample_i;
      full_d = 1'b1;
    end

    if (ce_q) begin
      // A fresh sample takes effect on the same tick that pops it.
      if (osr_q == '0) begin
        if (full_q) begin
          x_sel    = hold_q;
          cur_d    = hold_q;
          full_d   = 1'b0;
          primed_d = 1'b1;
        end else if (primed_q) begin
          uf_d = 1'b1;
        end
      end
      osr_d = (osr_q == OSR_W'(OSR - 1)) ? '0 : osr_q + OSR_W'(1);

      e = acc_q + {{2{x_sel[W-1]}}, x_sel};
`ifdef PDM_STIM_DITHER_EN
      e_cmp  = e + {{(AW-1){1'b0}}, lfsr_q[0]};
      bit_v  = ~e_cmp[AW-1];
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
`else
      bit_v = ~e[AW-1];
`endif
      acc_d = bit_v ? (e - FS_P) : (e + FS_P);

      // Channels tap the line after the shift, so a delay of 0 gives this tick's bit.
      dl_d = {dl_q[DL_N-2:0], bit_v};
      for (int c = 0; c < CH; c++) begin
        pdm_d[c] = dl_d[delay_i[c*DLY_W +: DLY_W]];
      end
    end

    if (clr_i) begin
      hold_d   = '0;
      full_d   = 1'b0;
      cur_d    = '0;
      acc_d    = '0;
      osr_d    = '0;
      dl_d     = '0;
      pdm_d    = '0;
      primed_d = 1'b0;
      uf_d     = 1'b0;
`ifdef PDM_STIM_DITHER_EN
      lfsr_d   = 16'hACE1;
`endif
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mclk_q   <= 1'b0;
      ce_q     <= 1'b0;
      hold_q   <= '0;
      full_q   <= 1'b0;
      cur_q    <= '0;
      acc_q    <= '0;
      osr_q    <= '0;
      dl_q     <= '0;
      pdm_q    <= '0;
      primed_q <= 1'b0;
      uf_q     <= 1'b0;
`ifdef PDM_STIM_DITHER_EN
      lfsr_q   <= 16'hACE1;
`endif
    end else begin
      cnt_q    <= cnt_d;
      mclk_q   <= mclk_d;
      ce_q     <= ce_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      cur_q    <= cur_d;
      acc_q    <= acc_d;
      osr_q    <= osr_d;
      dl_q     <= dl_d;
      pdm_q    <= pdm_d;
      primed_q <= primed_d;
      uf_q     <= uf_d;
`ifdef PDM_STIM_DITHER_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_pdm_stim_gen.sv
// tb_pdm_stim_gen: directed bench for pdm_stim_gen in its default build (no dither).
// A sigma-delta reference model pushes the expected {underflow_o, pdm_o} for each
// tick into exp_q. Each tick observed on the DUT pops one entry and compares it.
`timescale 1ns/1ps
module tb_pdm_stim_gen;

  localparam int CH = 4;
  localparam int W  = 12;
  localparam int FS = 2048;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             en, clr_i;
  logic [7:0]       prescaler;
  logic [W-1:0]     sample_i;
  logic             sample_valid_i;
  logic             sample_ready_o;
  logic [CH*4-1:0]  delay_i;
  logic             mclk_o, ce_pdm_o;
  logic [CH-1:0]    pdm_o;
  logic             underflow_o;

  pdm_stim_gen dut (
    .clk(clk), .rst(rst), .en(en), .clr_i(clr_i), .prescaler(prescaler),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .delay_i(delay_i), .mclk_o(mclk_o), .ce_pdm_o(ce_pdm_o), .pdm_o(pdm_o),
    .underflow_o(underflow_o)
  );

  int checks = 0;
  int errors = 0;
  int ones0  = 0;
  logic [CH:0] exp_q[$];

  // Reference model state
  int   m_acc, m_cur, m_hold, m_osr;
  bit   m_full, m_primed, m_uf;
  logic [15:0] m_hist;
  int   m_dly[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cur = 0; m_hold = 0; m_osr = 0;
    m_full = 0; m_primed = 0; m_uf = 0; m_hist = '0;
  endtask

  task automatic model_step(output logic [CH:0] v);
    int e;
    bit b;
    if (m_osr == 0) begin
      if (m_full) begin
        m_cur = m_hold; m_full = 0; m_primed = 1;
      end else if (m_primed) begin
        m_uf = 1;
      end
    end
    m_osr = (m_osr + 1) % 64;
    e = m_acc + m_cur;
    b = (e >= 0);
    m_acc = b ? e - FS : e + FS;
    m_hist = {m_hist[14:0], b};
    for (int c = 0; c < CH; c++) v[c] = m_hist[m_dly[c]];
    v[CH] = m_uf;
  endtask

  // Offer one sample; the model sees it as loaded from this point on.
  task automatic drive_sample(input int x);
    int w = 0;
    while (sample_ready_o !== 1'b1 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_load", 32'(sample_ready_o), 32'd1);
    sample_i = W'(x);
    sample_valid_i = 1'b1;
    @(posedge clk); #1;
    sample_valid_i = 1'b0;
    m_hold = x; m_full = 1;
  endtask

  // Wait for each tick, then compare the result visible one cycle later.
  task automatic check_ticks(input int n);
    logic [CH:0] v;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (ce_pdm_o !== 1'b1 && w < 200) begin
        @(posedge clk); #1; w++;
      end
      chk("tick_seen", 32'(ce_pdm_o), 32'd1);
      @(posedge clk); #1;
      v = exp_q.pop_front();
      chk("pdm_uf", 32'({underflow_o, pdm_o}), 32'(v));
      ones0 += int'(pdm_o[0]);
    end
  endtask

  task automatic run(input int n);
    logic [CH:0] v;
    for (int i = 0; i < n; i++) begin
      model_step(v);
      exp_q.push_back(v);
    end
    check_ticks(n);
  endtask

  // Stop the generator, let any pending tick drain, then clear the datapath.
  task automatic quiesce();
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    model_reset();
  endtask

  task automatic wait_ce(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ce_pdm_o !== 1'b1 && n < 1000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h;
    rst = 1'b1; en = 1'b0; clr_i = 1'b0; prescaler = 8'd0;
    sample_i = '0; sample_valid_i = 1'b0; delay_i = '0;
    for (int c = 0; c < CH; c++) m_dly[c] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mclk", 32'(mclk_o), 32'd0);
    chk("rst_ce", 32'(ce_pdm_o), 32'd0);
    chk("rst_pdm", 32'(pdm_o), 32'd0);
    chk("rst_ready", 32'(sample_ready_o), 32'd1);
    chk("rst_uf", 32'(underflow_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // prescaler=0: mclk toggles every clk, ce every 2 clk
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("p0_mclk", 32'(mclk_o), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("p0_ce", 32'(ce_pdm_o), (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // No sample ever loaded: cur=0 reused, no underflow across an OSR wrap
    quiesce();
    en = 1'b1;
    run(70);
    chk("uf_no_load", 32'(underflow_o), 32'd0);

    // Preloaded x=0: 1,0,1,0...
    quiesce();
    drive_sample(0);
    chk("ready_full", 32'(sample_ready_o), 32'd0);
    en = 1'b1;
    run(64);

    // prescaler=49 period/duty, then shrink to 9 mid-run
    quiesce();
    prescaler = 8'd49;
    en = 1'b1;
    wait_ce(n);
    wait_ce(n);
    chk("period_49", 32'(n), 32'd100);
    h = 0;
    while (mclk_o === 1'b1 && h < 500) begin
      @(posedge clk); #1; h++;
    end
    chk("mclk_high_49", 32'(h), 32'd50);
    wait_ce(n);
    prescaler = 8'd9;
    wait_ce(n);
    chk("period_9a", 32'(n), 32'd20);
    wait_ce(n);
    chk("period_9b", 32'(n), 32'd20);

    // Density at full-scale low, 3/4 and near full-scale high
    quiesce();
    prescaler = 8'd2;
    drive_sample(-2048);
    en = 1'b1;
    ones0 = 0; run(64);
    chk("ones_neg_fs", 32'(ones0), 32'd0);
    drive_sample(1024);
    ones0 = 0; run(64);
    chk("ones_1024", 32'(ones0), 32'd48);
    drive_sample(2047);
    ones0 = 0; run(64);
    chk("ones_2047_ge63", 32'(ones0 >= 63), 32'd1);

    // Per-channel delays {3,2,1,0}, x=512
    quiesce();
    delay_i = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int c = 0; c < CH; c++) m_dly[c] = c;
    drive_sample(512);
    en = 1'b1;
    ones0 = 0; run(64);
    chk("ones_512", 32'(ones0), 32'd40);

    // No further sample: underflow at the next OSR boundary, same density
    ones0 = 0; run(64);
    chk("ones_512_reuse", 32'(ones0), 32'd40);
    chk("uf_set", 32'(underflow_o), 32'd1);

    // Clear mid-stream with a sample offered in the same cycle
    clr_i = 1'b1; sample_valid_i = 1'b1; sample_i = 12'h123;
    @(posedge clk); #1;
    clr_i = 1'b0; sample_valid_i = 1'b0;
    chk("clr_ready", 32'(sample_ready_o), 32'd1);
    chk("clr_uf", 32'(underflow_o), 32'd0);
    chk("clr_pdm", 32'(pdm_o), 32'd0);
    model_reset();
    run(8);

    // Reset mid-stream while a tick is pending and the holding register is full
    drive_sample(700);
    chk("ready_full2", 32'(sample_ready_o), 32'd0);
    n = 0;
    while (ce_pdm_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("pre_rst_ce", 32'(ce_pdm_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ce", 32'(ce_pdm_o), 32'd0);
    chk("mid_rst_mclk", 32'(mclk_o), 32'd0);
    chk("mid_rst_pdm", 32'(pdm_o), 32'd0);
    chk("mid_rst_ready", 32'(sample_ready_o), 32'd1);
    chk("mid_rst_uf", 32'(underflow_o), 32'd0);
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
